// File: rtl/mem48_dp_hs.sv
// Dual-port word memory: port A read-only, port B read/write with lane strobes.
// Both ports: valid/ready request, registered 1-cycle read response, one-entry hold.
// Optional per-lane even parity: define MEM_PARITY_EN.
module mem48_dp_hs #(
   parameter  int unsigned DATA_W = 48,
   parameter  int unsigned LANE_W = 8,
   parameter  int unsigned WORDS  = 16384,
   localparam int unsigned LANES  = DATA_W / LANE_W,
   localparam int unsigned AW     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req_valid,
   output logic              a_req_ready,
   input  logic [AW-1:0]     a_addr,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              a_rready,
   input  logic              b_req_valid,
   output logic              b_req_ready,
   input  logic              b_we,
   input  logic [LANES-1:0]  b_wstrb,
   input  logic [AW-1:0]     b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   input  logic              b_rready,
   input  logic              perr_inject,
   output logic              a_perr,
   output logic              b_perr,
   output logic              perr_sticky
);

   logic [DATA_W-1:0] mem [WORDS];

   logic              a_acc, b_acc, b_rd_acc, b_wr;
   logic              a_in, b_in, a_hit;
   logic [DATA_W-1:0] a_word_c, b_word_c;
   logic              a_perr_c, b_perr_c;

   // Response slot frees when empty or being consumed this cycle
   assign a_req_ready = !a_rvalid || a_rready;
   assign b_req_ready = !b_rvalid || b_rready;

   assign a_acc    = a_req_valid && a_req_ready;
   assign b_acc    = b_req_valid && b_req_ready;
   assign b_rd_acc = b_acc && !b_we;
   assign a_in     = {1'b0, a_addr} < (AW+1)'(WORDS);
   assign b_in     = {1'b0, b_addr} < (AW+1)'(WORDS);
   assign b_wr     = b_acc && b_we && b_in;
   // A read colliding with a B write to the same word sees the new data
   assign a_hit    = b_wr && (a_addr == b_addr);

   // Lane-strobed data write
   always_ff @(posedge clk) begin
      if (b_wr) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (b_wstrb[i]) mem[b_addr][i*LANE_W +: LANE_W] <= b_wdata[i*LANE_W +: LANE_W];
         end
      end
   end

   // Read words; out-of-range reads return zero, A merges a colliding write
   always_comb begin
      a_word_c = '0;
      b_word_c = '0;
      if (a_in) a_word_c = mem[a_addr];
      if (b_in) b_word_c = mem[b_addr];
      if (a_hit) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (b_wstrb[i]) a_word_c[i*LANE_W +: LANE_W] = b_wdata[i*LANE_W +: LANE_W];
         end
      end
   end

`ifdef MEM_PARITY_EN
   logic [LANES-1:0] par [WORDS];
   logic [LANES-1:0] wpar_c, a_par_c, b_par_c;

   // Even parity per written lane; the test hook flips lane 0
   always_comb begin
      wpar_c = '0;
      for (int unsigned i = 0; i < LANES; i++) wpar_c[i] = ^b_wdata[i*LANE_W +: LANE_W];
      wpar_c[0] = wpar_c[0] ^ perr_inject;
   end

   // Parity write alongside data
   always_ff @(posedge clk) begin
      if (b_wr) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (b_wstrb[i]) par[b_addr][i] <= wpar_c[i];
         end
      end
   end

   // Parity fetch/merge and check at read accept
   always_comb begin
      a_par_c  = '0;
      b_par_c  = '0;
      a_perr_c = 1'b0;
      b_perr_c = 1'b0;
      if (a_in) a_par_c = par[a_addr];
      if (b_in) b_par_c = par[b_addr];
      if (a_hit) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (b_wstrb[i]) a_par_c[i] = wpar_c[i];
         end
      end
      for (int unsigned i = 0; i < LANES; i++) begin
         a_perr_c = a_perr_c | ((^a_word_c[i*LANE_W +: LANE_W]) ^ a_par_c[i]);
         b_perr_c = b_perr_c | ((^b_word_c[i*LANE_W +: LANE_W]) ^ b_par_c[i]);
      end
   end
`else
   logic unused_inject;
   assign unused_inject = perr_inject;
   assign a_perr_c      = 1'b0;
   assign b_perr_c      = 1'b0;
`endif

   // Port A response register with hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_rvalid <= 1'b0;
         a_rdata  <= '0;
         a_perr   <= 1'b0;
      end else if (a_acc) begin
         a_rvalid <= 1'b1;
         a_rdata  <= a_word_c;
         a_perr   <= a_perr_c;
      end else if (a_rready) begin
         a_rvalid <= 1'b0;
      end
   end

   // Port B response register with hold; writes produce no response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         b_rvalid <= 1'b0;
         b_rdata  <= '0;
         b_perr   <= 1'b0;
      end else if (b_rd_acc) begin
         b_rvalid <= 1'b1;
         b_rdata  <= b_word_c;
         b_perr   <= b_perr_c;
      end else if (b_rready) begin
         b_rvalid <= 1'b0;
      end
   end

   // Sticky error flag, set together with the registered per-port flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perr_sticky <= 1'b0;
      else        perr_sticky <= perr_sticky | (a_acc & a_perr_c) | (b_rd_acc & b_perr_c);
   end

endmodule

// File: tb/tb_mem48_dp_hs.sv
// Directed bench for mem48_dp_hs (WORDS=1000) with a response scoreboard.
module tb_mem48_dp_hs;

   localparam int unsigned DW = 48;
   localparam int unsigned LN = 6;
   localparam int unsigned NW = 1000;
   localparam int unsigned AW = 10;
`ifdef MEM_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic          clk, rst_n;
   logic          a_req_valid, a_req_ready, a_rvalid, a_rready, a_perr;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_rdata;
   logic          b_req_valid, b_req_ready, b_we, b_rvalid, b_rready, b_perr;
   logic [LN-1:0] b_wstrb;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata, b_rdata;
   logic          perr_inject, perr_sticky;

   mem48_dp_hs #(.DATA_W(48), .LANE_W(8), .WORDS(NW)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_addr(a_addr),
      .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_rready(a_rready),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_we(b_we),
      .b_wstrb(b_wstrb), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_rready(b_rready),
      .perr_inject(perr_inject), .a_perr(a_perr), .b_perr(b_perr),
      .perr_sticky(perr_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          p;
   } rsp_t;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] mdl [0:1023];
   bit            bad [0:1023];
   rsp_t          qa[$];
   rsp_t          qb[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_write(input logic [AW-1:0] ad, input logic [LN-1:0] st,
                              input logic [DW-1:0] wd, input logic inj);
      if (int'(ad) < int'(NW)) begin
         for (int i = 0; i < int'(LN); i++)
            if (st[i]) mdl[ad][i*8 +: 8] = wd[i*8 +: 8];
         if (st[0]) bad[ad] = inj;
      end
   endtask

   function automatic rsp_t model_read(input logic [AW-1:0] ad);
      rsp_t r;
      r = '0;
      if (int'(ad) < int'(NW)) begin
         r.d = mdl[ad];
         r.p = PAR ? bad[ad] : 1'b0;
      end
      return r;
   endfunction

   // One clock: score consumed responses, log accepted requests, advance.
   task automatic cycle();
      rsp_t e;
      @(negedge clk);
      if (rst_n && a_rvalid && a_rready) begin
         if (qa.size() == 0) begin
            n_cmp++; n_err++;
            $error("FAIL a_unexpected observed=%h expected=none", a_rdata);
         end else begin
            e = qa.pop_front();
            chk("a_rdata", 64'(a_rdata), 64'(e.d));
            chk("a_perr", 64'(a_perr), 64'(e.p));
         end
      end
      if (rst_n && b_rvalid && b_rready) begin
         if (qb.size() == 0) begin
            n_cmp++; n_err++;
            $error("FAIL b_unexpected observed=%h expected=none", b_rdata);
         end else begin
            e = qb.pop_front();
            chk("b_rdata", 64'(b_rdata), 64'(e.d));
            chk("b_perr", 64'(b_perr), 64'(e.p));
         end
      end
      if (rst_n && b_req_valid && b_req_ready) begin
         if (b_we) model_write(b_addr, b_wstrb, b_wdata, perr_inject);
         else      qb.push_back(model_read(b_addr));
      end
      if (rst_n && a_req_valid && a_req_ready) qa.push_back(model_read(a_addr));
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_req_valid = 1'b0;
      b_req_valid = 1'b0;
      b_we        = 1'b0;
      perr_inject = 1'b0;
   endtask

   task automatic bwr(input logic [AW-1:0] ad, input logic [LN-1:0] st,
                      input logic [DW-1:0] wd, input logic inj);
      b_req_valid = 1'b1; b_we = 1'b1; b_addr = ad; b_wstrb = st; b_wdata = wd;
      perr_inject = inj;
   endtask

   task automatic brd(input logic [AW-1:0] ad);
      b_req_valid = 1'b1; b_we = 1'b0; b_addr = ad; b_wstrb = '0;
   endtask

   task automatic ard(input logic [AW-1:0] ad);
      a_req_valid = 1'b1; a_addr = ad;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mdl[i] = '0;
         bad[i] = 1'b0;
      end
      rst_n = 1'b0;
      a_addr = '0; b_addr = '0; b_wstrb = '0; b_wdata = '0;
      a_rready = 1'b1; b_rready = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      // Reset state
      chk("rst_a_rvalid", 64'(a_rvalid), 64'(0));
      chk("rst_b_rvalid", 64'(b_rvalid), 64'(0));
      chk("rst_a_rdata", 64'(a_rdata), 64'(0));
      chk("rst_b_rdata", 64'(b_rdata), 64'(0));
      chk("rst_perr", 64'({a_perr, b_perr, perr_sticky}), 64'(0));
      rst_n = 1'b1;
      cycle();

      // Full write then A read, latency 1
      bwr(10'd5, 6'h3F, 48'h0123_4567_89AB, 1'b0); cycle();
      bwr(10'd0, 6'h3F, 48'h5555_0000_1234, 1'b0); cycle();
      idle(); ard(10'd5); cycle();
      idle();
      chk("t1_a_rvalid", 64'(a_rvalid), 64'(1));
      chk("t1_a_rdata", 64'(a_rdata), 64'h0123_4567_89AB);
      cycle();

      // Partial write lane 0, then zero-strobe write leaves word alone
      bwr(10'd5, 6'h01, 48'hFFFF_FFFF_FFFF, 1'b0); cycle();
      brd(10'd5); cycle();
      idle();
      chk("t2_b_rdata", 64'(b_rdata), 64'h0123_4567_89FF);
      cycle();
      bwr(10'd5, 6'h00, 48'h0, 1'b0); cycle();
      brd(10'd5); cycle();
      idle();
      chk("t2_strb0", 64'(b_rdata), 64'h0123_4567_89FF);
      cycle();

      // Same-cycle collision: write-first, full and partial
      ard(10'd9); bwr(10'd9, 6'h3F, 48'hAAAA_AAAA_AAAA, 1'b0); cycle();
      idle();
      chk("t3_collide", 64'(a_rdata), 64'hAAAA_AAAA_AAAA);
      cycle();
      ard(10'd9); bwr(10'd9, 6'h0C, 48'h1234_5678_9ABC, 1'b0); cycle();
      idle();
      chk("t3_collide_part", 64'(a_rdata), 64'hAAAA_5678_AAAA);
      cycle();

      // Backpressure hold, then one read per cycle streaming
      a_rready = 1'b0;
      ard(10'd5); cycle();
      ard(10'd9);
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("t4_hold_ready", 64'(a_req_ready), 64'(0));
         chk("t4_hold_rvalid", 64'(a_rvalid), 64'(1));
         chk("t4_hold_rdata", 64'(a_rdata), 64'h0123_4567_89FF);
      end
      a_rready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ard((k % 2 == 1) ? 10'd5 : 10'd0);
         cycle();
         chk("t4_stream_rvalid", 64'(a_rvalid), 64'(1));
      end
      idle(); cycle();
      chk("t4_drained", 64'(a_rvalid), 64'(0));

      // Out of range: read returns 0, write dropped
      ard(10'd1000); cycle();
      idle();
      chk("t5_oob_rdata", 64'(a_rdata), 64'(0));
      cycle();
      bwr(10'd1000, 6'h3F, 48'hDEAD_BEEF_0000, 1'b0); cycle();
      bwr(10'd1023, 6'h3F, 48'hDEAD_BEEF_1111, 1'b0); cycle();
      idle(); ard(10'd0); brd(10'd1023); cycle();
      idle();
      chk("t5_addr0", 64'(a_rdata), 64'h5555_0000_1234);
      chk("t5_oob_b", 64'(b_rdata), 64'(0));
      cycle();

      // Parity injection on lane 0
      bwr(10'd3, 6'h3F, 48'h1122_3344_5566, 1'b1); cycle();
      idle(); brd(10'd3); cycle();
      idle();
      chk("t6_b_perr", 64'(b_perr), 64'(PAR));
      chk("t6_sticky", 64'(perr_sticky), 64'(PAR));
      cycle();
      ard(10'd5); cycle();
      idle(); cycle();
      chk("t6_sticky_hold", 64'(perr_sticky), 64'(PAR));

      // Reset with a pending B response drops it at once
      b_rready = 1'b0;
      brd(10'd5); cycle();
      idle();
      chk("t5_pend_rvalid", 64'(b_rvalid), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("t5_rst_rvalid", 64'(b_rvalid), 64'(0));
      chk("t5_rst_sticky", 64'(perr_sticky), 64'(0));
      qa.delete();
      qb.delete();
      b_rready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      brd(10'd5); cycle();
      idle();
      chk("t5_after_rst", 64'(b_rdata), 64'h0123_4567_89FF);

      // Bounded drain of outstanding responses
      for (int k = 0; k < 10 && (qa.size() != 0 || qb.size() != 0); k++) cycle();
      chk("drain_qa", 64'(qa.size()), 64'(0));
      chk("drain_qb", 64'(qb.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
